// File: rtl/regfile_2w2r_sb.sv
// Two-write / two-read register file with per-byte write enables, optional
// same-cycle forwarding and a per-entry busy scoreboard with a registered population count.
module regfile_2w2r_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                RegWrite0,
  input  logic                RegWrite1,
  input  logic [ADDR_W-1:0]   WriteReg0,
  input  logic [ADDR_W-1:0]   WriteReg1,
  input  logic [DATA_W-1:0]   WriteData0,
  input  logic [DATA_W-1:0]   WriteData1,
  input  logic [DATA_W/8-1:0] ByteEn0,
  input  logic [DATA_W/8-1:0] ByteEn1,
  input  logic [ADDR_W-1:0]   ReadReg1,
  input  logic [ADDR_W-1:0]   ReadReg2,
  output logic [DATA_W-1:0]   ReadData1,
  output logic [DATA_W-1:0]   ReadData2,
  input  logic                IssueValid,
  input  logic [ADDR_W-1:0]   IssueReg,
  output logic                ReadBusy1,
  output logic                ReadBusy2,
  output logic [ADDR_W:0]     BusyCount
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int LANES = DATA_W/8;

  logic [DATA_W-1:0]           memReg [DEPTH];
  logic [DEPTH-1:0]            busyReg;
  logic [DEPTH-1:0]            busyNext;
  logic [ADDR_W:0]             busyCountReg;
  logic [ADDR_W:0]             busyCountNext;
  logic [LANES-1:0]            laneEn0;
  logic [LANES-1:0]            laneEn1;
  logic                        clr0;
  logic                        clr1;
  logic                        issueOk;
  logic [1:0][ADDR_W-1:0]      rdAddr;
  logic [1:0][DATA_W-1:0]      rdData;
  logic [1:0]                  rdBusy;

  function automatic logic isZeroReg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Writes and issues are masked during reset and for the hardwired zero entry,
  // so neither storage nor the forwarding paths ever see them.
  assign laneEn0 = (rst_n && RegWrite0 && !isZeroReg(WriteReg0)) ? ByteEn0 : '0;
  assign laneEn1 = (rst_n && RegWrite1 && !isZeroReg(WriteReg1)) ? ByteEn1 : '0;
  assign clr0    = |laneEn0;
  assign clr1    = |laneEn1;
  assign issueOk = rst_n && IssueValid && !isZeroReg(IssueReg);

  // Issue is applied last so it wins over a clearing write to the same entry.
  always_comb begin
    busyNext = busyReg;
    if (clr0)    busyNext[WriteReg0] = 1'b0;
    if (clr1)    busyNext[WriteReg1] = 1'b0;
    if (issueOk) busyNext[IssueReg]  = 1'b1;
  end

  always_comb begin
    busyCountNext = '0;
    for (int i = 0; i < DEPTH; i++)
      busyCountNext = busyCountNext + {{ADDR_W{1'b0}}, busyNext[i]};
  end

  // Port 1 lanes are assigned after port 0, so port 1 wins shared lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) memReg[i] <= '0;
      busyReg      <= '0;
      busyCountReg <= '0;
    end else begin
      for (int b = 0; b < LANES; b++) begin
        if (laneEn0[b]) memReg[WriteReg0][b*8 +: 8] <= WriteData0[b*8 +: 8];
        if (laneEn1[b]) memReg[WriteReg1][b*8 +: 8] <= WriteData1[b*8 +: 8];
      end
      busyReg      <= busyNext;
      busyCountReg <= busyCountNext;
    end
  end

  assign rdAddr[0] = ReadReg1;
  assign rdAddr[1] = ReadReg2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gRead
      logic [DATA_W-1:0] stored;
      logic              fwdClr;

      assign stored = memReg[rdAddr[gi]];
      assign fwdClr = (BYPASS != 0) &&
                      ((clr0 && (WriteReg0 == rdAddr[gi])) ||
                       (clr1 && (WriteReg1 == rdAddr[gi])));
      assign rdBusy[gi] = busyReg[rdAddr[gi]] && !fwdClr;

      for (genvar gl = 0; gl < LANES; gl++) begin : gLane
        logic hit0;
        logic hit1;
        assign hit0 = (BYPASS != 0) && laneEn0[gl] && (WriteReg0 == rdAddr[gi]);
        assign hit1 = (BYPASS != 0) && laneEn1[gl] && (WriteReg1 == rdAddr[gi]);
        assign rdData[gi][gl*8 +: 8] = hit1 ? WriteData1[gl*8 +: 8] :
                                       hit0 ? WriteData0[gl*8 +: 8] :
                                              stored[gl*8 +: 8];
      end
    end
  endgenerate

  assign ReadData1 = rdData[0];
  assign ReadData2 = rdData[1];
  assign ReadBusy1 = rdBusy[0];
  assign ReadBusy2 = rdBusy[1];
  assign BusyCount = busyCountReg;

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Scoreboard bench: the driver pushes expected outputs from an array model, and a
// negedge monitor compares both a forwarding and a non-forwarding instance.
module tb_regfile_2w2r_sb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWrite0, RegWrite1;
  logic [4:0]  WriteReg0, WriteReg1;
  logic [31:0] WriteData0, WriteData1;
  logic [3:0]  ByteEn0, ByteEn1;
  logic [4:0]  ReadReg1, ReadReg2;
  logic [31:0] ReadData1, ReadData2, nbReadData1, nbReadData2;
  logic        IssueValid;
  logic [4:0]  IssueReg;
  logic        ReadBusy1, ReadBusy2, nbReadBusy1, nbReadBusy2;
  logic [5:0]  BusyCount, nbBusyCount;

  int compared   = 0;
  int mismatched = 0;
  int txn        = 0;

  always #5 clk = ~clk;

  regfile_2w2r_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWrite0(RegWrite0), .RegWrite1(RegWrite1),
    .WriteReg0(WriteReg0), .WriteReg1(WriteReg1),
    .WriteData0(WriteData0), .WriteData1(WriteData1),
    .ByteEn0(ByteEn0), .ByteEn1(ByteEn1),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .IssueValid(IssueValid), .IssueReg(IssueReg),
    .ReadBusy1(ReadBusy1), .ReadBusy2(ReadBusy2),
    .BusyCount(BusyCount)
  );

  regfile_2w2r_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dutNb (
    .clk(clk), .rst_n(rst_n),
    .RegWrite0(RegWrite0), .RegWrite1(RegWrite1),
    .WriteReg0(WriteReg0), .WriteReg1(WriteReg1),
    .WriteData0(WriteData0), .WriteData1(WriteData1),
    .ByteEn0(ByteEn0), .ByteEn1(ByteEn1),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(nbReadData1), .ReadData2(nbReadData2),
    .IssueValid(IssueValid), .IssueReg(IssueReg),
    .ReadBusy1(nbReadBusy1), .ReadBusy2(nbReadBusy2),
    .BusyCount(nbBusyCount)
  );

  typedef struct {
    string       tag;
    logic [31:0] rd1, rd2, nrd1, nrd2;
    logic        rb1, rb2, nrb1, nrb2;
    logic [5:0]  bc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon;

  // Reference model: register contents and busy flags as plain arrays.
  logic [31:0] mMem [32];
  logic [31:0] mBusy;

  task automatic modelReset();
    for (int r = 0; r < 32; r++) mMem[r] = '0;
    mBusy = '0;
  endtask

  // Value entry r holds after this edge: port 0's write applied, then port 1's on top.
  function automatic logic [31:0] afterWrite(input int r);
    logic [31:0] v;
    v = mMem[r];
    if (r == 0) return '0;
    if (RegWrite0 && int'(WriteReg0) == r)
      for (int b = 0; b < 4; b++) if (ByteEn0[b]) v[b*8 +: 8] = WriteData0[b*8 +: 8];
    if (RegWrite1 && int'(WriteReg1) == r)
      for (int b = 0; b < 4; b++) if (ByteEn1[b]) v[b*8 +: 8] = WriteData1[b*8 +: 8];
    return v;
  endfunction

  function automatic logic clearing(input int r);
    return (r != 0) &&
           ((RegWrite0 && ByteEn0 != 4'h0 && int'(WriteReg0) == r) ||
            (RegWrite1 && ByteEn1 != 4'h0 && int'(WriteReg1) == r));
  endfunction

  function automatic exp_t mkExpected(input string tag);
    exp_t e;
    e.tag = tag;
    if (!rst_n) begin
      e.rd1 = '0; e.rd2 = '0; e.nrd1 = '0; e.nrd2 = '0;
      e.rb1 = 0;  e.rb2 = 0;  e.nrb1 = 0;  e.nrb2 = 0;
      e.bc  = '0;
      return e;
    end
    e.rd1  = afterWrite(int'(ReadReg1));
    e.rd2  = afterWrite(int'(ReadReg2));
    e.nrd1 = mMem[ReadReg1];
    e.nrd2 = mMem[ReadReg2];
    e.rb1  = mBusy[ReadReg1] && !clearing(int'(ReadReg1));
    e.rb2  = mBusy[ReadReg2] && !clearing(int'(ReadReg2));
    e.nrb1 = mBusy[ReadReg1];
    e.nrb2 = mBusy[ReadReg2];
    e.bc   = 6'($countones(mBusy));
    return e;
  endfunction

  task automatic modelEdge();
    logic [31:0] nxt [32];
    for (int r = 0; r < 32; r++) nxt[r] = afterWrite(r);
    for (int r = 0; r < 32; r++) if (clearing(r)) mBusy[r] = 1'b0;
    if (IssueValid && IssueReg != 5'd0) mBusy[IssueReg] = 1'b1;
    mMem = nxt;
  endtask

  task automatic setIdle();
    RegWrite0 = 0; RegWrite1 = 0; WriteReg0 = '0; WriteReg1 = '0;
    WriteData0 = '0; WriteData1 = '0; ByteEn0 = '0; ByteEn1 = '0;
    IssueValid = 0; IssueReg = '0; ReadReg1 = '0; ReadReg2 = '0;
  endtask

  // Inputs are already applied (posedge+1); push expectation, take the edge.
  task automatic step(input string tag);
    sbq.push_back(mkExpected(tag));
    @(posedge clk);
    if (rst_n) modelEdge();
    #1;
  endtask

  task automatic chk(input string what, input string tag,
                     input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s [%s] txn %0d: got %h, expected %h", what, tag, txn, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon = sbq.pop_front();
      txn++;
      $display("txn %0d %-8s rr=%0d/%0d rd=%h/%h busy=%b%b cnt=%0d",
               txn, mon.tag, ReadReg1, ReadReg2, ReadData1, ReadData2,
               ReadBusy1, ReadBusy2, BusyCount);
      chk("ReadData1",   mon.tag, ReadData1,   mon.rd1);
      chk("ReadData2",   mon.tag, ReadData2,   mon.rd2);
      chk("ReadBusy1",   mon.tag, {31'b0, ReadBusy1},   {31'b0, mon.rb1});
      chk("ReadBusy2",   mon.tag, {31'b0, ReadBusy2},   {31'b0, mon.rb2});
      chk("BusyCount",   mon.tag, {26'b0, BusyCount},   {26'b0, mon.bc});
      chk("nbReadData1", mon.tag, nbReadData1, mon.nrd1);
      chk("nbReadData2", mon.tag, nbReadData2, mon.nrd2);
      chk("nbReadBusy1", mon.tag, {31'b0, nbReadBusy1}, {31'b0, mon.nrb1});
      chk("nbReadBusy2", mon.tag, {31'b0, nbReadBusy2}, {31'b0, mon.nrb2});
      chk("nbBusyCount", mon.tag, {26'b0, nbBusyCount}, {26'b0, mon.bc});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    setIdle();
    modelReset();
    repeat (2) @(posedge clk);
    #1;

    // Activity while reset is held must be ignored.
    RegWrite0 = 1; WriteReg0 = 5'd2; WriteData0 = 32'hDEADBEEF; ByteEn0 = 4'hF;
    IssueValid = 1; IssueReg = 5'd4; ReadReg1 = 5'd2; ReadReg2 = 5'd4;
    step("inreset");

    setIdle(); rst_n = 1'b1; ReadReg1 = 5'd2; ReadReg2 = 5'd3;
    step("postrst");
    ReadReg1 = 5'd2; ReadReg2 = 5'd4;
    step("postrst2");

    // Byte-lane merge across two cycles.
    setIdle(); RegWrite0 = 1; WriteReg0 = 5'd1; WriteData0 = 32'h12345678; ByteEn0 = 4'hF;
    ReadReg1 = 5'd1;
    step("wr1a");
    setIdle(); RegWrite1 = 1; WriteReg1 = 5'd1; WriteData1 = 32'hAABBCCDD; ByteEn1 = 4'h3;
    ReadReg1 = 5'd1;
    step("wr1b");
    setIdle(); ReadReg1 = 5'd1;
    step("rd1");

    // Both ports to one entry, read in the same cycle.
    setIdle();
    RegWrite0 = 1; WriteReg0 = 5'd3; WriteData0 = 32'h11111111; ByteEn0 = 4'hF;
    RegWrite1 = 1; WriteReg1 = 5'd3; WriteData1 = 32'h22222222; ByteEn1 = 4'h6;
    ReadReg1 = 5'd3; ReadReg2 = 5'd1;
    step("dual3");
    setIdle(); ReadReg1 = 5'd3;
    step("rd3");

    // Entry 0 stays zero and never busy.
    setIdle(); RegWrite0 = 1; WriteReg0 = 5'd0; WriteData0 = 32'hFFFFFFFF; ByteEn0 = 4'hF;
    IssueValid = 1; IssueReg = 5'd0; ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    step("zero");
    setIdle();
    step("rdzero");

    // Busy scoreboard: set priority, clearing write, forwarded busy.
    setIdle(); IssueValid = 1; IssueReg = 5'd5; step("iss5");
    setIdle(); IssueValid = 1; IssueReg = 5'd6; step("iss6");
    setIdle(); ReadReg1 = 5'd5; ReadReg2 = 5'd6; step("busy56");
    setIdle(); RegWrite0 = 1; WriteReg0 = 5'd5; WriteData0 = 32'h55555555; ByteEn0 = 4'hF;
    IssueValid = 1; IssueReg = 5'd5; ReadReg1 = 5'd5; ReadReg2 = 5'd6;
    step("wriss5");
    setIdle(); RegWrite1 = 1; WriteReg1 = 5'd6; WriteData1 = 32'h66666666; ByteEn1 = 4'h1;
    ReadReg1 = 5'd6; ReadReg2 = 5'd5;
    step("wr6");
    setIdle(); ReadReg1 = 5'd6; ReadReg2 = 5'd5; step("busy5");
    // Write enable without byte enables is a no-op.
    setIdle(); RegWrite0 = 1; WriteReg0 = 5'd5; WriteData0 = 32'h0; ByteEn0 = 4'h0;
    ReadReg1 = 5'd5; step("noop5");
    setIdle(); ReadReg1 = 5'd5; ReadReg2 = 5'd1; step("chk5");

    // Reset dropped between edges with a write in flight.
    setIdle(); RegWrite0 = 1; WriteReg0 = 5'd1; WriteData0 = 32'hCAFEF00D; ByteEn0 = 4'hF;
    ReadReg1 = 5'd1; ReadReg2 = 5'd5;
    rst_n = 1'b0;
    modelReset();
    step("midrst");
    setIdle(); rst_n = 1'b1; ReadReg1 = 5'd1; ReadReg2 = 5'd5;
    step("release");

    // Randomized traffic concentrated on a few entries to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      RegWrite0  = 1'($urandom_range(0, 1));
      RegWrite1  = 1'($urandom_range(0, 1));
      WriteReg0  = 5'($urandom_range(0, 7));
      WriteReg1  = 5'($urandom_range(0, 7));
      WriteData0 = $urandom;
      WriteData1 = $urandom;
      ByteEn0    = 4'($urandom_range(0, 15));
      ByteEn1    = 4'($urandom_range(0, 15));
      IssueValid = ($urandom_range(0, 2) == 0);
      IssueReg   = 5'($urandom_range(0, 7));
      ReadReg1   = ($urandom_range(0, 1) == 1) ? WriteReg0 : 5'($urandom_range(0, 31));
      ReadReg2   = ($urandom_range(0, 1) == 1) ? WriteReg1 : 5'($urandom_range(0, 7));
      step("rand");
    end

    // Fill every issuable entry to reach the maximum count.
    for (int r = 1; r < 32; r++) begin
      setIdle(); IssueValid = 1; IssueReg = 5'(r); ReadReg1 = 5'(r);
      step("fill");
    end
    setIdle(); IssueValid = 1; IssueReg = 5'd7; ReadReg1 = 5'd0; ReadReg2 = 5'd31;
    step("full");
    setIdle(); step("fullchk");

    @(negedge clk);
    #1;
    compared++;
    if (sbq.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
